z88_kbd_ps2: RTL and testbench
==============================

// Module: z88_kbd_ps2
// PURPOSE
//  PS/2 keyboard front end that drives the 64-bit key matrix the gate array scans at port $B2.
//  Receives PS/2 set-2 frames, decodes make/break/E0 sequences and holds a sticky matrix image.
//  Sits between the board PS/2 connector and the gate array kbmat input.
//  Matrix bit = row*8+col; row n is selected by address line A(8+n); 1 = key pressed.
// PARAMETERS
//  TIMEOUT_CYC  10000  mck cycles without a ps2_clk fall before a partial frame is dropped (~1ms)
//  FILT_LEN     8      ps2_clk filter depth in mck cycles (used only with KBD_DEGLITCH_EN)
// PORTS
//  mck       in   1   9.83MHz master clock; the only clock in the block
//  rin_n     in   1   reset, asynchronous assert, active-low
//  ps2_clk   in   1   PS/2 clock, asynchronous, open-collector, idle high
//  ps2_dat   in   1   PS/2 data, asynchronous, idle high
//  kbmat     out  64  key matrix image, 1 = pressed
//  key_evt   out  1   1-cycle pulse on every mapped make or break
//  key_code  out  8   matrix index {1'b0,row[2:0],col[2:0]} of the last event, bit7 = 1 for break
//  frm_err   out  1   1-cycle pulse on parity, start, stop or timeout error
// BEHAVIOUR
//  Reset: kbmat=0, key_evt=0, key_code=0, frm_err=0. Receiver goes to IDLE and prefix flags clear.
//   Reset mid-frame discards the frame.
//  Inputs pass through a 2-FF synchroniser. A bit is sampled on the mck after the synced ps2_clk 1->0 edge.
//  Receiver FSM:
//   IDLE  : on a fall, dat=0 -> DATA, bitcnt=0; dat=1 -> frm_err, stay in IDLE.
//   DATA  : shift the bit in LSB-first; after the 8th bit -> PAR.
//   PAR   : require odd parity over data+par; store the result -> STOP.
//   STOP  : require dat=1. If the stop and parity checks pass, issue a byte strobe, else frm_err.
//           Then -> IDLE.
//  Watchdog: counter cleared on each fall. When it reaches TIMEOUT_CYC in any state other than IDLE:
//   -> IDLE, frm_err, the partial byte is dropped. The counter saturates and does not wrap.
//  Decoder (one byte strobe processed per cycle, latency 1 mck from strobe):
//   E0 -> ext=1.  F0 -> brk=1.
//   E1 -> skip the next 7 bytes (Pause); the flags clear.
//   AA with brk=0 -> kbmat=0 (BAT/hot-plug).
//   Any other byte -> look up {ext,byte} in z88_kbd_keymap.
//    Hit: kbmat[idx] = ~brk; key_evt=1; key_code={brk,idx[6:0]}.
//    Miss: no change, no key_evt.
//   ext and brk clear after every non-prefix byte.
//  Any frm_err also clears ext, brk and the skip count.
//  A repeated make of an already-set bit still pulses key_evt; kbmat is unchanged.
//  A break of a clear bit pulses key_evt; kbmat is unchanged.
//  Key map (fixed): 1C 'A'->45, 5A ENTER->6, 12 LSHIFT->54, 59 RSHIFT->63, 66 DEL->7,
//   E0 74 RIGHT->35, E0 6B LEFT->34, 29 SPACE->53. Full table lives in the package.
// CONFIGURATION
//  KBD_DEGLITCH_EN defined:
//   - synced ps2_clk feeds a FILT_LEN-bit shift register;
//   - the filtered clock goes low only when all bits are 0 and high only when all bits are 1;
//   - edges are taken from the filtered signal, adding FILT_LEN cycles of latency.
//  Undefined: edges are taken directly from the 2-FF synchronised signal; FILT_LEN is unused.
// STRUCTURE
//  z88_kbd_pkg: receiver state encodings; prefix constants 8'hE0/8'hF0/8'hE1/8'hAA;
//   matrix index constants (KEY_A=45 etc.); map entry type {valid,idx[5:0]}.
//  Sub-module z88_kbd_keymap: combinational 9-bit {ext,code} -> {hit,idx[5:0]} lookup.
//   Pure case table; no state.
//  Top level holds the synchroniser, optional filter, receiver FSM, watchdog, decoder and matrix register.
// TESTING
//  1. Frame 1C (start0, 00111000 LSB-first, par0, stop1) -> kbmat[45]=1, key_code=8'h2D, one key_evt pulse.
//  2. Bytes F0 1C after test 1 -> kbmat[45]=0, key_code=8'hAD; E0 74 -> kbmat[35]=1, bit 45 stays 0.
//  3. Byte 5A with wrong parity -> frm_err pulse, kbmat unchanged, no key_evt;
//     a following valid 5A -> kbmat[6]=1.
//  4. Stop after 4 data bits for >TIMEOUT_CYC -> one frm_err, FSM in IDLE; next full 12 -> kbmat[54]=1.
//  5. Hold 12 and 59, then send AA -> kbmat=0; E1 plus 7 bytes including 1C -> kbmat stays 0.
//  6. Assert rin_n low mid-frame while kbmat!=0 -> all outputs 0 at once; a fresh frame after release decodes.
//     With KBD_DEGLITCH_EN, a 3-cycle ps2_clk glitch is ignored.

Source files
------------

// File: rtl/z88_kbd_pkg.sv
// z88_kbd_pkg: shared types and constants for the Z88 PS/2 keyboard.
// Receiver states, prefix bytes, matrix indices, keymap entry type.
package z88_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } rx_state_t;

  localparam logic [7:0] PFX_EXT  = 8'hE0;
  localparam logic [7:0] PFX_BRK  = 8'hF0;
  localparam logic [7:0] PFX_PAU  = 8'hE1;
  localparam logic [7:0] CODE_BAT = 8'hAA;

  localparam logic [5:0] KEY_ENTER  = 6'd6;
  localparam logic [5:0] KEY_DEL    = 6'd7;
  localparam logic [5:0] KEY_LEFT   = 6'd34;
  localparam logic [5:0] KEY_RIGHT  = 6'd35;
  localparam logic [5:0] KEY_A      = 6'd45;
  localparam logic [5:0] KEY_SPACE  = 6'd53;
  localparam logic [5:0] KEY_LSHIFT = 6'd54;
  localparam logic [5:0] KEY_RSHIFT = 6'd63;

  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
  } map_ent_t;

  function automatic map_ent_t hit(logic [5:0] i);
    map_ent_t e;
    e.valid = 1'b1;
    e.idx   = i;
    return e;
  endfunction

endpackage

// File: rtl/z88_kbd_ps2_if.sv
// z88_kbd_ps2_if: PS/2 line pair plus matrix/event outputs.
// master = connector/host side, slave = keyboard front end.
interface z88_kbd_ps2_if;
  logic        ps2_clk;
  logic        ps2_dat;
  logic [63:0] kbmat;
  logic        key_evt;
  logic [7:0]  key_code;
  logic        frm_err;

  modport master (
    output ps2_clk, ps2_dat,
    input  kbmat, key_evt, key_code, frm_err
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output kbmat, key_evt, key_code, frm_err
  );
endinterface

// File: rtl/z88_kbd_keymap.sv
// z88_kbd_keymap: {ext,code} -> {hit,idx} translation.
// Pure lookup, no state.
module z88_kbd_keymap
  import z88_kbd_pkg::*;
(
  input  logic [8:0] key,
  output map_ent_t   ent
);

  // set-2 scan code to Z88 matrix index
  always_comb begin
    ent = '0;
    case (key)
      9'h01C:  ent = hit(KEY_A);
      9'h05A:  ent = hit(KEY_ENTER);
      9'h012:  ent = hit(KEY_LSHIFT);
      9'h059:  ent = hit(KEY_RSHIFT);
      9'h066:  ent = hit(KEY_DEL);
      9'h029:  ent = hit(KEY_SPACE);
      9'h174:  ent = hit(KEY_RIGHT);
      9'h16B:  ent = hit(KEY_LEFT);
      default: ent = '0;
    endcase
  end

endmodule

// File: rtl/z88_kbd_ps2.sv
// z88_kbd_ps2: PS/2 set-2 receiver driving the Z88 key matrix.
// Define KBD_DEGLITCH_EN to filter ps2_clk over FILT_LEN cycles.
module z88_kbd_ps2
  import z88_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 10000
`ifdef KBD_DEGLITCH_EN
  , parameter int FILT_LEN = 8
`endif
) (
  input logic          mck,
  input logic          rin_n,
  z88_kbd_ps2_if.slave bus
);

  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] TO_V = WW'(TIMEOUT_CYC);

  logic [1:0] csy, dsy;
  logic       dat, clk_f, clk_d, fall;

  // two-stage synchronisers for both PS/2 lines
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      csy <= 2'b11;
      dsy <= 2'b11;
    end else begin
      csy <= {csy[0], bus.ps2_clk};
      dsy <= {dsy[0], bus.ps2_dat};
    end
  end

  assign dat = dsy[1];

`ifdef KBD_DEGLITCH_EN
  logic [FILT_LEN-1:0] filt;

  // clock only changes after FILT_LEN agreeing samples
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      filt  <= '1;
      clk_f <= 1'b1;
    end else begin
      filt <= {filt[FILT_LEN-2:0], csy[1]};
      if (&filt)
        clk_f <= 1'b1;
      else if (~|filt)
        clk_f <= 1'b0;
    end
  end
`else
  assign clk_f = csy[1];
`endif

  // falling-edge detect on the (filtered) clock
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n)
      clk_d <= 1'b1;
    else
      clk_d <= clk_f;
  end

  assign fall = clk_d & ~clk_f;

  rx_state_t      state, state_n;
  logic [2:0]     bitcnt, bitcnt_n;
  logic [7:0]     shreg, shreg_n;
  logic           par_ok, par_n;
  logic [WW-1:0]  wdog, wdog_n;
  logic           byte_stb, rx_err;

  // receiver state and watchdog registers
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      state  <= ST_IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      par_ok <= 1'b0;
      wdog   <= '0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      par_ok <= par_n;
      wdog   <= wdog_n;
    end
  end

  // frame sequencing, parity/stop checks, timeout
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    par_n    = par_ok;
    byte_stb = 1'b0;
    rx_err   = 1'b0;
    wdog_n   = (wdog == TO_V) ? wdog : wdog + WW'(1);
    if (fall) begin
      wdog_n = '0;
      unique case (state)
        ST_IDLE: begin
          if (!dat) begin
            state_n  = ST_DATA;
            bitcnt_n = '0;
          end else begin
            rx_err = 1'b1;
          end
        end
        ST_DATA: begin
          shreg_n  = {dat, shreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7)
            state_n = ST_PAR;
        end
        ST_PAR: begin
          par_n   = ^{shreg, dat};
          state_n = ST_STOP;
        end
        ST_STOP: begin
          if (dat && par_ok)
            byte_stb = 1'b1;
          else
            rx_err = 1'b1;
          state_n = ST_IDLE;
        end
      endcase
    end else if (wdog == TO_V && state != ST_IDLE) begin
      state_n = ST_IDLE;
      rx_err  = 1'b1;
    end
  end

  logic        ext, brk;
  logic [2:0]  skip;
  logic [63:0] kbmat;
  logic        key_evt, frm_err;
  logic [7:0]  key_code;
  map_ent_t    ent;
  logic        is_bat;

  z88_kbd_keymap u_map (
    .key ({ext, shreg}),
    .ent (ent)
  );

  assign is_bat = (shreg == CODE_BAT) && !brk;

  // byte decoder: prefixes, pause skip, BAT clear, matrix update
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      ext      <= 1'b0;
      brk      <= 1'b0;
      skip     <= '0;
      kbmat    <= '0;
      key_evt  <= 1'b0;
      key_code <= '0;
      frm_err  <= 1'b0;
    end else begin
      key_evt <= 1'b0;
      frm_err <= rx_err;
      if (rx_err) begin
        ext  <= 1'b0;
        brk  <= 1'b0;
        skip <= '0;
      end else if (byte_stb) begin
        if (skip != 3'd0) begin
          skip <= skip - 3'd1;
        end else begin
          unique case (1'b1)
            shreg == PFX_EXT: ext <= 1'b1;
            shreg == PFX_BRK: brk <= 1'b1;
            shreg == PFX_PAU: begin
              skip <= 3'd7;
              ext  <= 1'b0;
              brk  <= 1'b0;
            end
            is_bat: begin
              kbmat <= '0;
              ext   <= 1'b0;
              brk   <= 1'b0;
            end
            default: begin
              if (ent.valid) begin
                kbmat[ent.idx] <= ~brk;
                key_evt        <= 1'b1;
                key_code       <= {brk, 1'b0, ent.idx};
              end
              ext <= 1'b0;
              brk <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.kbmat    = kbmat;
  assign bus.key_evt  = key_evt;
  assign bus.key_code = key_code;
  assign bus.frm_err  = frm_err;

endmodule

// File: tb/tb_z88_kbd_ps2.sv
// tb_z88_kbd_ps2: table vectors, corner sequences and random
// scan-code traffic against a byte-level keyboard model.
module tb_z88_kbd_ps2;

  localparam int TO   = 500;
  localparam int HALF = 12;
  localparam int GAP  = 14;

  logic mck = 1'b0;
  logic rin_n = 1'b0;
  always #5 mck = ~mck;

  z88_kbd_ps2_if bus ();

  z88_kbd_ps2 #(.TIMEOUT_CYC(TO)) dut (
    .mck   (mck),
    .rin_n (rin_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int evt_cnt = 0;
  int err_cnt = 0;

  always @(negedge mck) begin
    if (bus.key_evt === 1'b1) evt_cnt++;
    if (bus.frm_err === 1'b1) err_cnt++;
  end

  typedef struct {
    bit         ext;
    logic [7:0] code;
    int         idx;
  } km_t;
  km_t km[8];

  logic [63:0] m_mat;
  logic [7:0]  m_code;
  bit          m_ext, m_brk;
  int          m_skip, m_evt, m_err;

  function automatic int lookup(bit e, logic [7:0] c);
    for (int i = 0; i < 8; i++)
      if (km[i].ext == e && km[i].code == c) return km[i].idx;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int ix;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 0; m_brk = 0;
    end else if (b == 8'hAA && !m_brk) begin
      m_mat = '0; m_ext = 0; m_brk = 0;
    end else begin
      ix = lookup(m_ext, b);
      if (ix >= 0) begin
        m_mat[ix] = !m_brk;
        m_evt++;
        m_code = {m_brk, 7'(ix)};
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic model_err();
    m_err++; m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic model_reset();
    m_mat = '0; m_code = '0; m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic sync_chk(input string nm);
    chk({nm, ".kbmat"}, bus.kbmat, m_mat);
    chk({nm, ".code"}, 64'(bus.key_code), 64'(m_code));
    chk({nm, ".evts"}, 64'(evt_cnt), 64'(m_evt));
    chk({nm, ".errs"}, 64'(err_cnt), 64'(m_err));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge mck);
  endtask

  task automatic ps2_bit(input logic d);
    bus.ps2_dat = d;
    cyc(HALF);
    bus.ps2_clk = 1'b0;
    cyc(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop
  task automatic send_frame(input logic [7:0] b, input int kind);
    logic p;
    p = ~^b;
    if (kind == 1) p = ~p;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(kind == 2 ? 1'b0 : 1'b1);
    bus.ps2_dat = 1'b1;
    cyc(GAP);
    if (kind == 0) model_byte(b);
    else model_err();
  endtask

  typedef struct {
    logic [7:0] b;
    int         kind;
    int         idx;
    bit         val;
    logic [7:0] code;
    int         devt;
    int         derr;
  } vec_t;
  vec_t tv[13];

  int e0, r0, k;
  logic [7:0] pool[14];
  logic [7:0] rb;
  int kd;

  initial begin
    km[0] = '{0, 8'h1C, 45}; km[1] = '{0, 8'h5A, 6};
    km[2] = '{0, 8'h12, 54}; km[3] = '{0, 8'h59, 63};
    km[4] = '{0, 8'h66, 7};  km[5] = '{1, 8'h74, 35};
    km[6] = '{1, 8'h6B, 34}; km[7] = '{0, 8'h29, 53};
    tv[0]  = '{8'h1C, 0, 45, 1, 8'h2D, 1, 0};
    tv[1]  = '{8'hF0, 0, 45, 1, 8'h2D, 0, 0};
    tv[2]  = '{8'h1C, 0, 45, 0, 8'hAD, 1, 0};
    tv[3]  = '{8'hE0, 0, 35, 0, 8'hAD, 0, 0};
    tv[4]  = '{8'h74, 0, 35, 1, 8'h23, 1, 0};
    tv[5]  = '{8'h5A, 1, 6,  0, 8'h23, 0, 1};
    tv[6]  = '{8'h5A, 0, 6,  1, 8'h06, 1, 0};
    tv[7]  = '{8'h5A, 0, 6,  1, 8'h06, 1, 0};
    tv[8]  = '{8'hF0, 0, 53, 0, 8'h06, 0, 0};
    tv[9]  = '{8'h29, 0, 53, 0, 8'hB5, 1, 0};
    tv[10] = '{8'h66, 2, 7,  0, 8'hB5, 0, 1};
    tv[11] = '{8'hE0, 0, 34, 0, 8'hB5, 0, 0};
    tv[12] = '{8'h6B, 0, 34, 1, 8'h22, 1, 0};
    pool = '{8'h1C, 8'h5A, 8'h12, 8'h59, 8'h66, 8'h74, 8'h6B,
             8'h29, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hAA, 8'h00};
    model_reset();
    m_evt = 0; m_err = 0;

    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    cyc(5);
    chk("rst.kbmat", bus.kbmat, '0);
    chk("rst.code", 64'(bus.key_code), 0);
    chk("rst.evt", 64'(bus.key_evt), 0);
    chk("rst.err", 64'(bus.frm_err), 0);
    @(negedge mck);
    rin_n = 1'b1;
    cyc(5);

    for (int i = 0; i < 13; i++) begin
      e0 = evt_cnt; r0 = err_cnt;
      send_frame(tv[i].b, tv[i].kind);
      chk($sformatf("tv%0d.bit", i), 64'(bus.kbmat[tv[i].idx]),
          64'(tv[i].val));
      chk($sformatf("tv%0d.code", i), 64'(bus.key_code),
          64'(tv[i].code));
      chk($sformatf("tv%0d.evt", i), 64'(evt_cnt - e0),
          64'(tv[i].devt));
      chk($sformatf("tv%0d.err", i), 64'(err_cnt - r0),
          64'(tv[i].derr));
    end
    chk("tv.kbmat", bus.kbmat, 64'h0000_000C_0000_0040);
    sync_chk("tv");

    r0 = err_cnt;
    bus.ps2_dat = 1'b1;
    cyc(HALF);
    bus.ps2_clk = 1'b0;
    cyc(HALF);
    bus.ps2_clk = 1'b1;
    cyc(GAP);
    model_err();
    chk("start.err", 64'(err_cnt - r0), 1);
    sync_chk("start");

    send_frame(8'hF0, 0);
    r0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    bus.ps2_dat = 1'b1;
    k = 0;
    while (err_cnt == r0 && k < TO + 100) begin
      @(posedge mck);
      k++;
    end
    chk("to.fired", 64'(err_cnt - r0), 1);
    chk("to.not_early", 64'(k >= TO - 30), 1);
    chk("to.not_late", 64'(k <= TO + 30), 1);
    cyc(50);
    chk("to.once", 64'(err_cnt - r0), 1);
    model_err();
    send_frame(8'h5A, 0);
    chk("to.brk_clr", 64'(bus.key_code), 64'h06);
    send_frame(8'h12, 0);
    chk("to.lshift", 64'(bus.kbmat[54]), 1);
    sync_chk("to");

    send_frame(8'h59, 0);
    chk("bat.rshift", 64'(bus.kbmat[63]), 1);
    e0 = evt_cnt;
    send_frame(8'hF0, 0);
    send_frame(8'hAA, 0);
    chk("bat.brk_aa", bus.kbmat, m_mat);
    chk("bat.brk_evt", 64'(evt_cnt - e0), 0);
    send_frame(8'hAA, 0);
    chk("bat.clear", bus.kbmat, '0);
    e0 = evt_cnt;
    send_frame(8'hE1, 0);
    send_frame(8'h1C, 0);
    send_frame(8'h77, 0);
    send_frame(8'hE1, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h77, 0);
    chk("pause.kbmat", bus.kbmat, '0);
    chk("pause.evt", 64'(evt_cnt - e0), 0);
    send_frame(8'h1C, 0);
    chk("pause.after", bus.kbmat, 64'h0000_2000_0000_0000);
    sync_chk("pause");

    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    rin_n = 1'b0;
    #1;
    chk("arst.kbmat", bus.kbmat, '0);
    chk("arst.code", 64'(bus.key_code), 0);
    chk("arst.evt", 64'(bus.key_evt), 0);
    chk("arst.err", 64'(bus.frm_err), 0);
    bus.ps2_dat = 1'b1;
    bus.ps2_clk = 1'b1;
    model_reset();
    cyc(5);
    @(negedge mck);
    rin_n = 1'b1;
    cyc(5);
    send_frame(8'h29, 0);
    chk("arst.fresh", bus.kbmat, 64'h0020_0000_0000_0000);
    chk("arst.fcode", 64'(bus.key_code), 64'h35);
    sync_chk("arst");

`ifdef KBD_DEGLITCH_EN
    r0 = err_cnt;
    bus.ps2_dat = 1'b0;
    cyc(4);
    bus.ps2_clk = 1'b0;
    cyc(3);
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    cyc(TO + 50);
    chk("glitch.err", 64'(err_cnt - r0), 0);
    send_frame(8'h66, 0);
    sync_chk("glitch");
`endif

    for (int i = 0; i < 120; i++) begin
      rb = pool[$urandom_range(0, 13)];
      if (rb == 8'h00) rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 39) == 0) rb = 8'hE1;
      kd = 0;
      if ($urandom_range(0, 15) == 0) kd = 1;
      else if ($urandom_range(0, 31) == 0) kd = 2;
      send_frame(rb, kd);
      sync_chk($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
